// File: rtl/prod_bcd_pkg.sv
// Shared types and constants for the Booth-product BCD converter.
// Segment patterns are active-low, bit order gfedcba.
package prod_bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // True when DIGITS decimal digits can hold the largest magnitude 2^(2N-1).
  function automatic bit digits_ok(input int n, input int d);
    longint p10;
    p10 = 1;
    for (int i = 0; i < d; i++) p10 = p10 * 10;
    return p10 > (longint'(1) << (2 * n - 1));
  endfunction

endpackage

// File: rtl/prod_bcd_conv_sevseg.sv
// Single BCD digit to active-low 7-segment pattern (gfedcba).
// Non-decimal codes show blank.
module bcd_to_sevseg
  import prod_bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Pure lookup; codes 10..15 never occur from the converter.
  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/prod_bcd_conv.sv
// Signed Booth product -> sign + BCD digits via double dabble.
// Optional 7-segment output under PROD_BCD_SEVSEG_EN.
module prod_bcd_conv
  import prod_bcd_pkg::*;
#(
  parameter int N      = 8,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Load,
  input  logic [2*N-1:0]        Product,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Sign,
`ifdef PROD_BCD_SEVSEG_EN
  output logic [4*DIGITS-1:0]   BCD,
  output logic [7*(DIGITS+1)-1:0] HEX
`else
  output logic [4*DIGITS-1:0]   BCD
`endif
);

  localparam int W  = 2 * N;
  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);
  localparam bit DIGITS_OK = digits_ok(N, DIGITS);

  if (!DIGITS_OK) begin : g_bad_digits
    $error("prod_bcd_conv: DIGITS too small for N");
  end

  state_e         state_q, state_d;
  logic           load_q;
  logic [AW-1:0]  acc_q, acc_d;
  logic [W-1:0]   mag_q, mag_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic [AW-1:0]  bcd_q, bcd_d;
  logic           sign_q, sign_d;

  logic           start;
  logic [AW-1:0]  adj;
  logic [AW+W-1:0] sh;

  assign start = Load & ~load_q & (state_q == S_IDLE);

  // Next-state: capture on start, add-3 then shift while SHIFT.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    adj     = acc_q;
    sh      = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d+:4] >= 4'd5) adj[4*d+:4] = acc_q[4*d+:4] + 4'd3;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          neg_d   = Product[W-1];
          mag_d   = Product[W-1] ? (~Product + 1'b1) : Product;
          acc_d   = '0;
          cnt_d   = CW'(W);
        end
      end
      S_SHIFT: begin
        sh    = {adj, mag_q} << 1;
        acc_d = sh[AW+W-1:W];
        mag_d = sh[W-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          bcd_d   = sh[AW+W-1:W];
          sign_d  = neg_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      load_q  <= 1'b0;
      acc_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= Load;
      acc_q   <= acc_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = (state_q == S_DONE);
  assign Sign = sign_q;
  assign BCD  = bcd_q;

`ifdef PROD_BCD_SEVSEG_EN
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_to_sevseg u_seg (
      .digit_i (bcd_q[4*g+:4]),
      .seg_o   (HEX[7*g+:7])
    );
  end
  assign HEX[7*DIGITS+:7] = sign_q ? SEG_MINUS : SEG_BLANK;
`endif

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Directed bench for prod_bcd_conv (default N=8, DIGITS=5).
// Define PROD_BCD_SEVSEG_EN to also check the HEX port.
module tb_prod_bcd_conv;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Load = 1'b0;
  logic [15:0] Product = '0;
  logic        Busy, Done, Sign;
  logic [19:0] BCD;
`ifdef PROD_BCD_SEVSEG_EN
  logic [41:0] HEX;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [19:0] prev_bcd = '0;
  logic        prev_sign = 1'b0;

  always #5 clk = ~clk;

  prod_bcd_conv #(.N(8), .DIGITS(5)) dut (
    .clk     (clk),
    .Reset   (Reset),
    .Load    (Load),
    .Product (Product),
    .Busy    (Busy),
    .Done    (Done),
    .Sign    (Sign),
`ifdef PROD_BCD_SEVSEG_EN
    .BCD     (BCD),
    .HEX     (HEX)
`else
    .BCD     (BCD)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion: rising Load, then 40 bounded sample cycles.
  task automatic run(input string tag, input logic [15:0] p,
                     input logic es, input logic [19:0] eb);
    int bc, dc, di;
    Load = 1'b0;
    step();
    Product = p;
    Load = 1'b1;
    step();
    bc = 0; dc = 0; di = -1;
    for (int i = 0; i < 40; i++) begin
      if (Busy) bc++;
      if (Done) begin
        dc++;
        if (di < 0) di = i;
      end
      if (i == 8) begin
        check({tag, "_hold_bcd"}, 32'(BCD), 32'(prev_bcd));
        check({tag, "_hold_sign"}, 32'(Sign), 32'(prev_sign));
      end
      if (i == 3) Load = 1'b0;
      step();
    end
    check({tag, "_done_at"}, 32'(di), 32'd16);
    check({tag, "_done_cnt"}, 32'(dc), 32'd1);
    check({tag, "_busy_cnt"}, 32'(bc), 32'd17);
    check({tag, "_sign"}, 32'(Sign), 32'(es));
    check({tag, "_bcd"}, 32'(BCD), 32'(eb));
    prev_bcd = eb;
    prev_sign = es;
  endtask

  initial begin
    int dc;
    Reset = 1'b1;
    step();
    step();
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_sign", 32'(Sign), 32'd0);
    check("rst_bcd", 32'(BCD), 32'd0);
`ifdef PROD_BCD_SEVSEG_EN
    check("rst_hex_top", 32'(HEX[41:35]), 32'h7f);
    check("rst_hex_d0", 32'(HEX[6:0]), 32'h40);
`endif
    Reset = 1'b0;
    step();

    run("zero", 16'h0000, 1'b0, 20'h00000);
    run("p16384", 16'h4000, 1'b0, 20'h16384);
    run("n16256", 16'hC080, 1'b1, 20'h16256);
    run("n32768", 16'h8000, 1'b1, 20'h32768);
    run("n1", 16'hFFFF, 1'b1, 20'h00001);

    // Load held high for a long time: one conversion only.
    Load = 1'b0;
    step();
    Product = 16'h0007;
    Load = 1'b1;
    dc = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (Done) dc++;
    end
    Load = 1'b0;
    check("held_done_cnt", 32'(dc), 32'd1);
    check("held_bcd", 32'(BCD), 32'h00007);
    check("held_sign", 32'(Sign), 32'd0);
    prev_bcd = 20'h00007;
    prev_sign = 1'b0;

    // Second rise during a conversion is ignored.
    step();
    Product = 16'h0064;
    Load = 1'b1;
    step();
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) begin
        Load = 1'b0;
        Product = 16'h0001;
      end
      if (i == 5) Load = 1'b1;
      if (Done) dc++;
      step();
    end
    Load = 1'b0;
    check("ign_done_cnt", 32'(dc), 32'd1);
    check("ign_bcd", 32'(BCD), 32'h00100);
    check("ign_sign", 32'(Sign), 32'd0);
    prev_bcd = 20'h00100;

    // Reset in the middle of SHIFT.
    step();
    Product = 16'hFC18;
    Load = 1'b1;
    step();
    for (int i = 0; i < 8; i++) step();
    check("mid_busy_pre", 32'(Busy), 32'd1);
    Reset = 1'b1;
    Load = 1'b0;
    step();
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_done", 32'(Done), 32'd0);
    check("mid_rst_bcd", 32'(BCD), 32'd0);
    check("mid_rst_sign", 32'(Sign), 32'd0);
    Reset = 1'b0;
    prev_bcd = '0;
    prev_sign = 1'b0;
    run("p25", 16'h0019, 1'b0, 20'h00025);

    run("n7", 16'hFFF9, 1'b1, 20'h00007);
`ifdef PROD_BCD_SEVSEG_EN
    check("hex_top", 32'(HEX[41:35]), 32'h3f);
    check("hex_d0", 32'(HEX[6:0]), 32'h78);
    check("hex_d1", 32'(HEX[13:7]), 32'h40);
    check("hex_d4", 32'(HEX[34:28]), 32'h40);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
